fetch_decoder: RTL

- Sequential successor to the CPU's combinational instruction decoder.
- Pulls instruction bytes from the fetch byte stream and assembles 1-, 2- or 3-byte instructions, including the inline data byte that previously arrived on a separate input.
- Registers one fully decoded instruction, with immediate widened to WIDTH, and presents it to the execute stage over a valid/ready handshake.
- Datapath width is parametrised; flush supports taken branches.

---
 rtl/fetch_decoder.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_decoder.sv
// fetch_decoder
//   Sequential instruction decoder. Assembles 1-, 2- or 3-byte instructions
//   from the fetch byte stream. The bytes are the header H, the argument L
//   and the inline data D. It registers one fully decoded instruction and
//   holds it for the execute stage over a valid/ready handshake.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                drop the partial assembly and the held instruction
//   byte_valid/ready     fetch byte stream handshake; byte_data is the byte
//   accum                accumulator value, captured by load-indirect (H=44)
//   dec_valid/ready      decoded instruction handshake toward execute
//   op, illegal, rhs     decoded opcode, trap flag, WIDTH-bit operand
//   bytes                instruction length (1..3)
//   source_*             operand source (immediate / ram / indirect)
//   relative_*           address base for ram/indirect operands
//   cond                 IF condition {else-flag, negate}
module fetch_decoder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic [WIDTH-1:0] accum,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [3:0]       op,
  output logic             illegal,
  output logic [WIDTH-1:0] rhs,
  output logic [1:0]       bytes,
  output logic             source_imm,
  output logic             source_ram,
  output logic             source_indirect,
  output logic             relative_data,
  output logic             relative_stack,
  output logic [1:0]       cond
);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_HALT   = 4'd1;
  localparam logic [3:0] OP_PUSH   = 4'd2;
  localparam logic [3:0] OP_POP    = 4'd3;
  localparam logic [3:0] OP_NOT    = 4'd4;
  localparam logic [3:0] OP_OUT_LO = 4'd5;
  localparam logic [3:0] OP_SET_DP = 4'd6;
  localparam logic [3:0] OP_LOAD   = 4'd7;
  localparam logic [3:0] OP_STORE  = 4'd8;
  localparam logic [3:0] OP_ADD    = 4'd9;
  localparam logic [3:0] OP_SUB    = 4'd10;
  localparam logic [3:0] OP_AND    = 4'd11;
  localparam logic [3:0] OP_OR     = 4'd12;
  localparam logic [3:0] OP_XOR    = 4'd13;
  localparam logic [3:0] OP_BRANCH = 4'd14;
  localparam logic [3:0] OP_IF     = 4'd15;

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_ARG  = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // Branch offset: 11-bit two's-complement {H[2:0],L} widened to WIDTH.
  function automatic logic [WIDTH-1:0] sext11(input logic signed [10:0] v);
    logic signed [WIDTH-1:0] w;
    w = WIDTH'(v);
    return w;
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       h_q, h_d;
  logic [7:0]       l_q, l_d;

  logic [3:0]       op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] rhs_q, rhs_d;
  logic [1:0]       bytes_q, bytes_d;
  logic             src_imm_q, src_imm_d;
  logic             src_ram_q, src_ram_d;
  logic             src_ind_q, src_ind_d;
  logic             rel_data_q, rel_data_d;
  logic             rel_stack_q, rel_stack_d;
  logic [1:0]       cond_q, cond_d;

  logic             accept;
  logic             complete;
  logic [7:0]       h_cur, l_cur, d_cur;

  // Decode results for the instruction completing this cycle.
  logic [3:0]       dc_op;
  logic             dc_illegal;
  logic [WIDTH-1:0] dc_rhs;
  logic [1:0]       dc_bytes;
  logic             dc_imm, dc_ram, dc_ind, dc_rdata, dc_rstack;
  logic [1:0]       dc_cond;

  assign byte_ready = (state_q != S_HOLD);
  assign dec_valid  = (state_q == S_HOLD);
  assign accept     = byte_valid & byte_ready;

  // The byte being accepted takes the place of whichever field the current
  // state is collecting, so decode can run on the completing cycle.
  assign h_cur = (state_q == S_OP)  ? byte_data : h_q;
  assign l_cur = (state_q == S_ARG) ? byte_data : l_q;
  assign d_cur = byte_data;

  // Next-state and byte capture
  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    l_d      = l_q;
    complete = 1'b0;
    unique case (state_q)
      S_OP: begin
        if (accept) begin
          h_d = byte_data;
          if (!byte_data[7]) begin
            complete = 1'b1;
            state_d  = S_HOLD;
          end else begin
            state_d  = S_ARG;
          end
        end
      end
      S_ARG: begin
        if (accept) begin
          l_d = byte_data;
          // Only one-arg forms with H[2:1]=01 carry an inline data byte.
          if (h_q[7:6] == 2'b10 && h_q[2:1] == 2'b01) begin
            state_d = S_DATA;
          end else begin
            complete = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          complete = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (dec_ready) state_d = S_OP;
      end
      default: state_d = S_OP;
    endcase
    if (flush) begin
      state_d  = S_OP;
      complete = 1'b0;
    end
  end

  // Instruction decode
  always_comb begin
    dc_op      = OP_NOP;
    dc_illegal = 1'b0;
    dc_rhs     = '0;
    dc_bytes   = 2'd1;
    dc_imm     = 1'b0;
    dc_ram     = 1'b0;
    dc_ind     = 1'b0;
    dc_rdata   = 1'b0;
    dc_rstack  = 1'b0;
    dc_cond    = 2'b00;
    if (!h_cur[7]) begin
      dc_bytes = 2'd1;
      unique case (h_cur)
        8'h00: dc_op = OP_NOP;
        8'h01: dc_op = OP_HALT;
        8'h04: dc_op = OP_PUSH;
        8'h05: dc_op = OP_POP;
        8'h07: dc_op = OP_NOT;
        8'h08: dc_op = OP_OUT_LO;
        8'h0A: dc_op = OP_SET_DP;
        8'h44: begin
          dc_op    = OP_LOAD;
          dc_ram   = 1'b1;
          dc_rdata = 1'b1;
          dc_rhs   = accum;
        end
        default: dc_illegal = 1'b1;
      endcase
    end else if (!h_cur[6]) begin
      unique case (h_cur[5:3])
        3'd0: dc_op = OP_LOAD;
        3'd1: dc_op = OP_ADD;
        3'd2: dc_op = OP_STORE;
        3'd3: dc_op = OP_SUB;
        3'd4: dc_op = OP_AND;
        3'd5: dc_op = OP_OR;
        3'd6: dc_op = OP_XOR;
        default: dc_illegal = 1'b1;
      endcase
      dc_imm = ~h_cur[2];
      dc_ram = h_cur[2] & ~h_cur[0];
      dc_ind = h_cur[2] &  h_cur[0];
      if (h_cur[2]) begin
        dc_rstack = h_cur[1];
        dc_rdata  = ~h_cur[1];
        dc_rhs    = WIDTH'(l_cur);
      end else begin
        unique case (h_cur[1:0])
          2'b00: dc_rhs = WIDTH'(l_cur);
          2'b01: dc_rhs = WIDTH'(l_cur) << 8;
          2'b10: dc_rhs = WIDTH'(d_cur);
          default: dc_rhs = WIDTH'(d_cur) << 8;
        endcase
      end
      dc_bytes = (h_cur[2:1] == 2'b01) ? 2'd3 : 2'd2;
    end else begin
      dc_bytes = 2'd2;
      if (h_cur[5:3] == 3'b000) begin
        dc_op  = OP_BRANCH;
        dc_rhs = sext11({h_cur[2:0], l_cur});
      end else if (h_cur[5:3] == 3'b110) begin
        dc_op = OP_IF;
        if (h_cur[2:0] == 3'b000 && (l_cur & 8'hEE) == 8'h00) begin
          dc_cond = {l_cur[4], l_cur[0]};
        end else begin
          dc_illegal = 1'b1;
        end
      end else begin
        dc_illegal = 1'b1;
      end
    end
  end

  // Output capture on the completing byte
  always_comb begin
    op_d        = op_q;
    illegal_d   = illegal_q;
    rhs_d       = rhs_q;
    bytes_d     = bytes_q;
    src_imm_d   = src_imm_q;
    src_ram_d   = src_ram_q;
    src_ind_d   = src_ind_q;
    rel_data_d  = rel_data_q;
    rel_stack_d = rel_stack_q;
    cond_d      = cond_q;
    if (complete) begin
      op_d        = dc_op;
      illegal_d   = dc_illegal;
      rhs_d       = dc_rhs;
      bytes_d     = dc_bytes;
      src_imm_d   = dc_imm;
      src_ram_d   = dc_ram;
      src_ind_d   = dc_ind;
      rel_data_d  = dc_rdata;
      rel_stack_d = dc_rstack;
      cond_d      = dc_cond;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OP;
      h_q         <= '0;
      l_q         <= '0;
      op_q        <= '0;
      illegal_q   <= 1'b0;
      rhs_q       <= '0;
      bytes_q     <= '0;
      src_imm_q   <= 1'b0;
      src_ram_q   <= 1'b0;
      src_ind_q   <= 1'b0;
      rel_data_q  <= 1'b0;
      rel_stack_q <= 1'b0;
      cond_q      <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      l_q         <= l_d;
      op_q        <= op_d;
      illegal_q   <= illegal_d;
      rhs_q       <= rhs_d;
      bytes_q     <= bytes_d;
      src_imm_q   <= src_imm_d;
      src_ram_q   <= src_ram_d;
      src_ind_q   <= src_ind_d;
      rel_data_q  <= rel_data_d;
      rel_stack_q <= rel_stack_d;
      cond_q      <= cond_d;
    end
  end

  assign op              = op_q;
  assign illegal         = illegal_q;
  assign rhs             = rhs_q;
  assign bytes           = bytes_q;
  assign source_imm      = src_imm_q;
  assign source_ram      = src_ram_q;
  assign source_indirect = src_ind_q;
  assign relative_data   = rel_data_q;
  assign relative_stack  = rel_stack_q;
  assign cond            = cond_q;

endmodule
